// File: rtl/word_fetch.sv
// word_fetch: upstream feeder for the joiner stage.
//
// Fetches a 16-bit word as two consecutive bytes from a byte-wide synchronous
// instruction memory: the low byte at pc, the high byte at pc+1. The bytes are
// presented on low/high with a valid/ready handshake toward decode. The block
// owns the program counter. pc advances by 2 per accepted word, and pc_load
// redirects it for jumps and branches.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   pc_load      load pc with pc_load_val and abort any in-flight fetch
//   pc_load_val  new pc value
//   mem_addr     byte address to instruction memory
//   mem_rd       read strobe to instruction memory
//   mem_rdata    read data, valid one cycle after the mem_rd cycle
//   low, high    bytes of the fetched word
//   word_valid   low/high hold a complete word
//   word_ready   consumer accepts the word this cycle
//   pc           address of the low byte of the current/in-flight word
module word_fetch #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        low,
  output logic [7:0]        high,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    S_REQ_LO = 2'd0,
    S_REQ_HI = 2'd1,
    S_CAP    = 2'd2,
    S_VALID  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        low_q, low_d;
  logic [7:0]        high_q, high_d;
  logic              vld_q, vld_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ_LO;
      pc_q    <= RESET_PC;
      low_q   <= 8'h00;
      high_q  <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      low_q   <= low_d;
      high_q  <= high_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    low_d    = low_q;
    high_d   = high_q;
    vld_d    = vld_q;
    mem_rd   = 1'b0;
    mem_addr = pc_q;

    case (state_q)
      S_REQ_LO: begin
        mem_rd  = 1'b1;
        state_d = S_REQ_HI;
      end
      S_REQ_HI: begin
        // Read data returning now belongs to the low-byte request of last cycle.
        mem_rd   = 1'b1;
        mem_addr = pc_q + ADDR_W'(1);
        low_d    = mem_rdata;
        state_d  = S_CAP;
      end
      S_CAP: begin
        high_d  = mem_rdata;
        vld_d   = 1'b1;
        state_d = S_VALID;
      end
      S_VALID: begin
        if (word_ready) begin
          pc_d    = pc_q + ADDR_W'(2);
          vld_d   = 1'b0;
          state_d = S_REQ_LO;
        end
      end
      default: begin
        state_d = S_REQ_LO;
      end
    endcase

    // A redirect wins over every transition. A word handed over on the same
    // edge still counts as consumed, but the byte in flight is dropped.
    if (pc_load) begin
      pc_d    = pc_load_val;
      state_d = S_REQ_LO;
      vld_d   = 1'b0;
      low_d   = low_q;
      high_d  = high_q;
    end

    if (rst) begin
      mem_rd = 1'b0;
    end
  end

  assign low        = low_q;
  assign high       = high_q;
  assign word_valid = vld_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_word_fetch.sv
// Testbench for word_fetch: byte memory mem[a] = a ^ 0xA5, a transaction-level
// reference model (fetch age counter, expected pc/bytes), and a scoreboard that
// checks each word presented by the DUT against the queued prediction.
module tb_word_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic [7:0] low, high;
  logic       word_valid;
  logic       word_ready;
  logic [7:0] pc;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];

  typedef struct {
    logic [7:0] pc;
    logic [7:0] lo;
    logic [7:0] hi;
  } word_t;
  word_t exp_q[$];

  // Reference model state
  bit         m_known = 1'b0;
  logic [7:0] m_pc;
  int         m_age;     // cycles since the current fetch began, saturating at 3
  logic [7:0] m_lo, m_hi;
  bit         seen = 1'b0;

  word_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .low         (low),
    .high        (high),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // Synchronous memory; random garbage when not read exposes stray captures.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 8'($urandom);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word's low byte is mem[pc], its high byte mem[pc+1]; it appears
  // three cycles after the fetch begins, and a fetch begins after reset, after
  // an acceptance, or after a pc load.
  always @(posedge clk) begin
    if (rst) begin
      m_known = 1'b1;
      m_pc    = 8'h00;
      m_age   = 0;
      m_lo    = 8'h00;
      m_hi    = 8'h00;
      exp_q.delete();
    end else if (m_known) begin
      if (pc_load) begin
        m_pc  = pc_load_val;
        m_age = 0;
      end else if (m_age == 3) begin
        if (word_ready) begin
          m_pc  = m_pc + 8'd2;
          m_age = 0;
        end
      end else begin
        if (m_age == 1) m_lo = mem[m_pc];
        if (m_age == 2) m_hi = mem[8'(m_pc + 8'd1)];
        m_age++;
        if (m_age == 3) exp_q.push_back('{pc: m_pc, lo: m_lo, hi: m_hi});
      end
    end
  end

  // Per-cycle interface checks against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("mem_rd_in_reset", mem_rd, 0);
    end else if (m_known) begin
      check("word_valid", word_valid, (m_age == 3) ? 1 : 0);
      check("pc", pc, m_pc);
      check("low", low, m_lo);
      check("high", high, m_hi);
      check("mem_rd", mem_rd, (m_age < 2) ? 1 : 0);
      if (m_age < 2) check("mem_addr", mem_addr, 8'(m_pc + 8'(m_age)));
    end
  end

  // Scoreboard monitor: pops one prediction per word the DUT presents.
  always @(negedge clk) begin
    word_t w;
    if (!rst && word_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        w = exp_q.pop_front();
        check("sb_pc", pc, w.pc);
        check("sb_low", low, w.lo);
        check("sb_high", high, w.hi);
      end
    end
    if (!word_valid) seen = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_age(input int k);
    int n = 0;
    while (m_age != k && n < 50) begin
      step();
      n++;
    end
    if (m_age != k) check("wait_age_timeout", m_age, k);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hA5;
    rst = 1'b1; pc_load = 1'b0; pc_load_val = 8'h00; word_ready = 1'b1;
    step(); step();
    check("reset_pc", pc, 0);
    check("reset_valid", word_valid, 0);
    check("reset_low", low, 0);
    check("reset_high", high, 0);
    rst = 1'b0;

    // First two words, ready tied high.
    wait_age(3);
    check("word0_low", low, 8'hA5);
    check("word0_high", high, 8'hA4);
    step();
    wait_age(3);
    check("word1_low", low, 8'hA7);
    check("word1_high", high, 8'hA6);
    check("word1_pc", pc, 8'h02);

    // Backpressure for 5 cycles.
    word_ready = 1'b0;
    repeat (5) step();
    word_ready = 1'b1;
    step();
    check("after_bp_pc", pc, 8'h04);

    // pc_load during the high-byte request.
    wait_age(1);
    pc_load = 1'b1; pc_load_val = 8'h40;
    step();
    pc_load = 1'b0;
    wait_age(3);
    check("load40_low", low, 8'hE5);
    check("load40_high", high, 8'hE4);
    step();

    // Wrap-around at 0xFF.
    pc_load = 1'b1; pc_load_val = 8'hFF;
    step();
    pc_load = 1'b0;
    wait_age(3);
    check("wrap_low", low, 8'h5A);
    check("wrap_high", high, 8'hA5);
    step();
    check("wrap_next_pc", pc, 8'h01);

    // Simultaneous load and acceptance.
    wait_age(3);
    pc_load = 1'b1; pc_load_val = 8'h10;
    step();
    pc_load = 1'b0;
    check("load_accept_pc", pc, 8'h10);
    check("load_accept_valid", word_valid, 0);

    // Reset during the capture cycle.
    wait_age(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_pc", pc, 0);
    check("midreset_low", low, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      word_ready  = ($urandom_range(0, 3) != 0);
      pc_load     = ($urandom_range(0, 19) == 0);
      pc_load_val = 8'($urandom);
      rst         = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; pc_load = 1'b0; word_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
